// File: rtl/vote_controller.sv
`default_nettype none
// ============================================================================
// Module      : vote_controller
// Description : Poll session controller. Sequences IDLE/OPEN/TALLY/DONE,
//               accepts one-hot ballots over valid/ready with a per-voter
//               lockout, keeps saturating tallies and finds the winner with a
//               serial scan through one shared comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_controller #(
  parameter int N_CAND  = 5,
  parameter int CNT_W   = 32,
  parameter int LOCKOUT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      close,
  input  logic                      clear,
  input  logic                      ballot_valid,
  input  logic [N_CAND-1:0]         ballot_sel,
  output logic                      ballot_ready,
  output logic                      polls_open,
  output logic                      busy,
  output logic                      spoil_pulse,
  output logic                      result_valid,
  output logic [$clog2(N_CAND)-1:0] winner_idx,
  output logic [N_CAND-1:0]         winner_mask,
  output logic [CNT_W-1:0]          win_count,
  output logic                      tie,
  output logic [CNT_W-1:0]          total_votes,
  output logic [CNT_W-1:0]          spoiled
);

  localparam int IDX_W = $clog2(N_CAND);
  localparam int LK_W  = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);
  localparam logic [LK_W-1:0]  LK_LOAD  = LK_W'(LOCKOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_TALLY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  tally [N_CAND];
  logic [LK_W-1:0]   lock_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic [CNT_W-1:0]  run_max;
  logic [N_CAND-1:0] run_mask;
  logic [IDX_W-1:0]  run_idx;

  logic              start_go;
  logic              accept;
  logic              sel_onehot;
  logic              scan_last;
  logic [CNT_W-1:0]  cur_tally;
  logic [N_CAND-1:0] scan_bit;
  logic [CNT_W-1:0]  cmp_max;
  logic [N_CAND-1:0] cmp_mask;
  logic [IDX_W-1:0]  cmp_idx;

  assign polls_open   = (state == S_OPEN);
  assign busy         = (state == S_TALLY);
  assign result_valid = (state == S_DONE);
  assign ballot_ready = polls_open && (lock_cnt == '0);
  assign start_go     = (state == S_IDLE) && start;
  assign accept       = ballot_valid && ballot_ready;
  assign sel_onehot   = (ballot_sel != '0) && ((ballot_sel & (ballot_sel - 1'b1)) == '0);
  assign scan_last    = (scan_idx == LAST_IDX);
  assign cur_tally    = tally[scan_idx];
  assign scan_bit     = N_CAND'(1) << scan_idx;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state decode; each command is honoured only in its own phase
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start)     next_state = S_OPEN;
      S_OPEN:  if (close)     next_state = S_TALLY;
      S_TALLY: if (scan_last) next_state = S_DONE;
      S_DONE:  if (clear)     next_state = S_IDLE;
      default:                next_state = S_IDLE;
    endcase
  end

  // Shared comparator: fold the candidate under the scan index into the running max
  always_comb begin
    cmp_max  = run_max;
    cmp_mask = run_mask;
    cmp_idx  = run_idx;
    if ((scan_idx == '0) || (cur_tally > run_max)) begin
      cmp_max  = cur_tally;
      cmp_mask = scan_bit;
      cmp_idx  = scan_idx;
    end else if (cur_tally == run_max) begin
      cmp_mask = run_mask | scan_bit;
    end
  end

  // Datapath: ballot counting, lockout, scan progress and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CAND; i++) tally[i] <= '0;
      lock_cnt    <= '0;
      scan_idx    <= '0;
      run_max     <= '0;
      run_mask    <= '0;
      run_idx     <= '0;
      spoil_pulse <= 1'b0;
      total_votes <= '0;
      spoiled     <= '0;
      winner_idx  <= '0;
      winner_mask <= '0;
      win_count   <= '0;
      tie         <= 1'b0;
    end else begin
      spoil_pulse <= 1'b0;
      if (start_go) begin
        for (int i = 0; i < N_CAND; i++) tally[i] <= '0;
        lock_cnt    <= '0;
        scan_idx    <= '0;
        run_max     <= '0;
        run_mask    <= '0;
        run_idx     <= '0;
        total_votes <= '0;
        spoiled     <= '0;
        winner_idx  <= '0;
        winner_mask <= '0;
        win_count   <= '0;
        tie         <= 1'b0;
      end else begin
        if (accept)                lock_cnt <= LK_LOAD;
        else if (lock_cnt != '0)   lock_cnt <= lock_cnt - 1'b1;

        if (accept) begin
          if (sel_onehot) begin
            for (int i = 0; i < N_CAND; i++) begin
              if (ballot_sel[i] && (tally[i] != CNT_MAX)) tally[i] <= tally[i] + 1'b1;
            end
            if (total_votes != CNT_MAX) total_votes <= total_votes + 1'b1;
          end else begin
            if (spoiled != CNT_MAX) spoiled <= spoiled + 1'b1;
            spoil_pulse <= 1'b1;
          end
        end

        if (state == S_TALLY) begin
          run_max  <= cmp_max;
          run_mask <= cmp_mask;
          run_idx  <= cmp_idx;
          if (scan_last) begin
            scan_idx    <= '0;
            win_count   <= cmp_max;
            winner_mask <= cmp_mask;
            winner_idx  <= cmp_idx;
            tie         <= ((cmp_mask & (cmp_mask - 1'b1)) != '0);
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vote_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_controller
// Description : Scoreboard bench for vote_controller. Stimulus pushes the
//               expected poll result when polls close; a monitor pops and
//               compares when result_valid rises. A second instance with
//               narrow counters and no lockout covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_controller;

  localparam int NC = 5;
  localparam int LK = 3;
  localparam longint MAXV = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, close = 1'b0, clear = 1'b0, ballot_valid = 1'b0;
  logic [NC-1:0] ballot_sel = '0;
  logic ballot_ready, polls_open, busy, spoil_pulse, result_valid, tie;
  logic [2:0] winner_idx;
  logic [NC-1:0] winner_mask;
  logic [31:0] win_count, total_votes, spoiled;

  logic s_start = 1'b0, s_close = 1'b0, s_clear = 1'b0, s_valid = 1'b0;
  logic [NC-1:0] s_sel = '0;
  logic s_ready, s_open, s_busy, s_spoil, s_rv, s_tie;
  logic [2:0] s_idx;
  logic [NC-1:0] s_mask;
  logic [2:0] s_win, s_total, s_spoiled;

  vote_controller #(.N_CAND(NC), .CNT_W(32), .LOCKOUT(LK)) dut (
    .clk(clk), .rst(rst), .start(start), .close(close), .clear(clear),
    .ballot_valid(ballot_valid), .ballot_sel(ballot_sel), .ballot_ready(ballot_ready),
    .polls_open(polls_open), .busy(busy), .spoil_pulse(spoil_pulse),
    .result_valid(result_valid), .winner_idx(winner_idx), .winner_mask(winner_mask),
    .win_count(win_count), .tie(tie), .total_votes(total_votes), .spoiled(spoiled)
  );

  vote_controller #(.N_CAND(NC), .CNT_W(3), .LOCKOUT(0)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .close(s_close), .clear(s_clear),
    .ballot_valid(s_valid), .ballot_sel(s_sel), .ballot_ready(s_ready),
    .polls_open(s_open), .busy(s_busy), .spoil_pulse(s_spoil),
    .result_valid(s_rv), .winner_idx(s_idx), .winner_mask(s_mask),
    .win_count(s_win), .tie(s_tie), .total_votes(s_total), .spoiled(s_spoiled)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          idx;
    logic [4:0]  mask;
    longint      win;
    bit          tie;
    longint      tot;
    longint      sp;
    int          ccyc;
  } exp_t;
  exp_t expq[$];

  longint cnt[NC];
  longint m_total, m_sp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    m_total = 0;
    m_sp = 0;
  endfunction

  function automatic void model_accept(input logic [4:0] sel);
    if ($countones(sel) == 1) begin
      for (int i = 0; i < NC; i++) if (sel[i] && cnt[i] < MAXV) cnt[i]++;
      if (m_total < MAXV) m_total++;
    end else if (m_sp < MAXV) begin
      m_sp++;
    end
  endfunction

  // The poll result as defined by the rules: highest count, all holders, first holder
  task automatic push_expect();
    exp_t e;
    longint best = 0;
    for (int i = 0; i < NC; i++) if (cnt[i] > best) best = cnt[i];
    e.win = best;
    e.mask = '0;
    e.idx = -1;
    for (int i = 0; i < NC; i++) begin
      if (cnt[i] == best) begin
        e.mask[i] = 1'b1;
        if (e.idx < 0) e.idx = i;
      end
    end
    e.tie = ($countones(e.mask) > 1);
    e.tot = m_total;
    e.sp = m_sp;
    e.ccyc = cyc;
    expq.push_back(e);
  endtask

  // Monitor: compare on each rising edge of result_valid
  logic rv_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (result_valid && !rv_q) begin
      if (expq.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = expq.pop_front();
        check("winner_idx", winner_idx, e.idx);
        check("winner_mask", winner_mask, e.mask);
        check("win_count", win_count, e.win);
        check("tie", tie, e.tie);
        check("res_total", total_votes, e.tot);
        check("res_spoiled", spoiled, e.sp);
        check("latency", cyc - e.ccyc, NC);
      end
    end
    rv_q = result_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
    check("start_open", {polls_open, ballot_ready}, 2'b11);
    check("start_clr", {result_valid, total_votes, spoiled, win_count}, 0);
  endtask

  // One ballot; optional close on the same edge. During lockout a different
  // ballot is held valid to show it is not consumed.
  task automatic cast(input logic [4:0] sel, input bit cl);
    int n = 0;
    while (!ballot_ready && n < 40) begin step(); n++; end
    if (!ballot_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    ballot_valid = 1'b1;
    ballot_sel = sel;
    close = cl;
    step();
    close = 1'b0;
    model_accept(sel);
    check("spoil_pulse", spoil_pulse, ($countones(sel) != 1));
    check("total_votes", total_votes, m_total);
    check("spoiled", spoiled, m_sp);
    if (cl) begin
      ballot_valid = 1'b0;
      push_expect();
      check("busy", busy, 1);
      return;
    end
    ballot_sel = ~sel;
    for (int j = 0; j < LK; j++) begin
      check("lockout_ready", ballot_ready, 0);
      step();
    end
    ballot_valid = 1'b0;
    check("ready_back", ballot_ready, 1);
    check("held_not_taken", {total_votes, spoiled}, {m_total[31:0], m_sp[31:0]});
  endtask

  task automatic do_close(input bit push, input bit poke_start);
    close = 1'b1;
    step();
    close = 1'b0;
    if (push) push_expect();
    check("busy", busy, 1);
    if (poke_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  task automatic finish_poll();
    int n = 0;
    while (!result_valid && n < 40) begin step(); n++; end
    if (!result_valid) check("result_timeout", 0, 1);
    step();
    check("done_hold", {polls_open, busy, result_valid}, 3'b001);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("cleared", {result_valid, polls_open}, 2'b00);
  endtask

  logic [4:0] rsel;
  int nb;
  bit last_cl;

  initial begin
    model_clear();
    step();
    check("reset_outputs", {ballot_ready, polls_open, busy, spoil_pulse, result_valid,
                            winner_idx, winner_mask, win_count, tie, total_votes, spoiled}, 0);
    step();
    rst = 1'b1;
    step();
    check("idle_after_reset", {polls_open, ballot_ready, result_valid}, 0);

    // Clear winner 2
    do_start();
    cast(5'b00001, 0); cast(5'b00100, 0); cast(5'b00100, 0);
    cast(5'b10000, 0); cast(5'b00100, 0);
    do_close(1, 0);
    finish_poll();
    check("result_held_idle", win_count, 3);

    // Two-way tie 1/3
    do_start();
    cast(5'b00010, 0); cast(5'b01000, 0); cast(5'b00010, 0); cast(5'b01000, 0);
    do_close(1, 0);
    finish_poll();

    // Spoiled only: zero and multi-hot
    do_start();
    cast(5'b00000, 0); cast(5'b00011, 0);
    do_close(1, 0);
    finish_poll();

    // Close on the ballot edge breaks the 0/4 tie; start during TALLY ignored
    do_start();
    cast(5'b00001, 0); cast(5'b10000, 0);
    cast(5'b10000, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    finish_poll();

    // Randomised polls
    for (int p = 0; p < 5; p++) begin
      do_start();
      nb = $urandom_range(0, 9);
      last_cl = 1'b0;
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 4) == 0) rsel = 5'($urandom);
        else rsel = 5'(1 << $urandom_range(0, 4));
        last_cl = (b == nb - 1) && ($urandom_range(0, 1) == 1);
        cast(rsel, last_cl);
      end
      if (!last_cl) do_close(1, $urandom_range(0, 1) == 1);
      finish_poll();
    end

    // Reset asserted mid-scan
    do_start();
    cast(5'b00010, 0); cast(5'b01000, 0);
    do_close(0, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("reset_midscan", {ballot_ready, polls_open, busy, spoil_pulse, result_valid,
                            winner_idx, winner_mask, win_count, tie, total_votes, spoiled}, 0);
    step();
    rst = 1'b1;
    step();
    check("idle_after_midscan", {polls_open, busy, result_valid}, 0);
    do_start();
    cast(5'b00100, 0);
    do_close(1, 0);
    finish_poll();

    // Saturation on the narrow instance, back-to-back ballots
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    s_valid = 1'b1;
    s_sel = 5'b00001;
    for (int i = 0; i < 9; i++) begin
      check("sat_ready", s_ready, 1);
      step();
    end
    s_valid = 1'b0;
    check("sat_total", s_total, 7);
    check("sat_spoiled", s_spoiled, 0);
    s_close = 1'b1;
    step();
    s_close = 1'b0;
    nb = 0;
    while (!s_rv && nb < 40) begin step(); nb++; end
    check("sat_result_valid", s_rv, 1);
    check("sat_win", s_win, 7);
    check("sat_idx_mask_tie", {s_idx, s_mask, s_tie}, {3'd0, 5'b00001, 1'b0});

    repeat (3) step();
    check("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
